// File: rtl/axis_spi_flash_reader.sv
// axis_spi_flash_reader: sequences a SPI flash read (opcode, address, dummy bytes) through a
// byte-wide SPI bridge and forwards the data-phase responses as an AXI-Stream packet.
module axis_spi_flash_reader #(
    parameter logic [7:0] CMD_BYTE        = 8'h03,
    parameter int         ADDR_BYTES      = 3,
    parameter int         LEN_WIDTH       = 16,
    parameter int         CS_SETUP_CYCLES = 2,
    parameter int         CS_HOLD_CYCLES  = 2,
    parameter int         CS_IDLE_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    sresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [8*ADDR_BYTES-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]    req_len,
    output logic                    spi_i_tvalid,
    input  logic                    spi_i_tready,
    output logic [7:0]              spi_i_tdata,
    input  logic                    spi_o_tvalid,
    output logic                    spi_o_tready,
    input  logic [7:0]              spi_o_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [7:0]              m_tdata,
    output logic                    m_tlast,
    output logic                    csn
);
    localparam int MAXC = (CS_SETUP_CYCLES > CS_HOLD_CYCLES ? CS_SETUP_CYCLES : CS_HOLD_CYCLES) > CS_IDLE_CYCLES ?
                          (CS_SETUP_CYCLES > CS_HOLD_CYCLES ? CS_SETUP_CYCLES : CS_HOLD_CYCLES) : CS_IDLE_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam int HW = 8 * (ADDR_BYTES + 1);
    localparam logic [CW-1:0] SU_LAST = CW'(CS_SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HO_LAST = CW'(CS_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ID_LAST = CW'(CS_IDLE_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HDR, S_HDR_RSP, S_DATA, S_DATA_RSP, S_HOLD, S_GAP} state_t;

    state_t                r_state, w_next;
    logic [HW-1:0]         r_hdr;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic [2:0]            r_hdr_idx;
    logic [CW-1:0]         r_cnt;
    logic                  r_csn;
    logic                  w_cnt_done;

    assign csn = r_csn;
    assign w_cnt_done = r_cnt == (r_state == S_SETUP ? SU_LAST : r_state == S_HOLD ? HO_LAST : ID_LAST);

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        spi_i_tvalid = 1'b0;
        spi_i_tdata  = 8'h00;
        spi_o_tready = 1'b0;
        m_tvalid     = 1'b0;
        m_tdata      = 8'h00;
        m_tlast      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                w_next    = req_valid ? S_SETUP : S_IDLE;
            end
            S_SETUP: w_next = w_cnt_done ? S_HDR : S_SETUP;
            S_HDR: begin
                spi_i_tvalid = 1'b1;
                spi_i_tdata  = r_hdr[HW-1 -: 8];
                w_next       = spi_i_tready ? S_HDR_RSP : S_HDR;
            end
            S_HDR_RSP: begin
                spi_o_tready = 1'b1;
                w_next       = !spi_o_tvalid ? S_HDR_RSP : (r_hdr_idx == 3'(ADDR_BYTES)) ? S_DATA : S_HDR;
            end
            S_DATA: begin
                spi_i_tvalid = 1'b1;
                w_next       = spi_i_tready ? S_DATA_RSP : S_DATA;
            end
            // Backpressure passes straight to the bridge so it stalls rather than drops data
            S_DATA_RSP: begin
                m_tvalid     = spi_o_tvalid;
                m_tdata      = spi_o_tdata;
                m_tlast      = r_rem == '0;
                spi_o_tready = m_tready;
                w_next       = !(spi_o_tvalid && m_tready) ? S_DATA_RSP : (r_rem == '0) ? S_HOLD : S_DATA;
            end
            S_HOLD:  w_next = w_cnt_done ? S_GAP : S_HOLD;
            S_GAP:   w_next = w_cnt_done ? S_IDLE : S_GAP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_state   <= S_IDLE;
            r_csn     <= 1'b1;
            r_hdr     <= '0;
            r_rem     <= '0;
            r_hdr_idx <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next == r_state) ? r_cnt + 1'b1 : '0;
            if (r_state == S_IDLE && req_valid) begin
                r_hdr     <= {CMD_BYTE, req_addr};
                r_rem     <= req_len;
                r_hdr_idx <= '0;
                r_csn     <= 1'b0;
            end
            if (r_state == S_HDR_RSP && spi_o_tvalid) begin
                r_hdr_idx <= r_hdr_idx + 1'b1;
                r_hdr     <= r_hdr << 8;
            end
            if (r_state == S_DATA_RSP && spi_o_tvalid && m_tready && r_rem != '0)
                r_rem <= r_rem - 1'b1;
            if (r_state == S_HOLD && w_cnt_done)
                r_csn <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_spi_flash_reader.sv
// tb_axis_spi_flash_reader: random bridge/flash responder plus a packet-level model of the
// expected MOSI stream, output beats and chip-select timing.
module tb_axis_spi_flash_reader;
    localparam int AB = 3, SU = 2, HO = 2, ID = 4;

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [23:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        spi_i_tvalid, spi_i_tready = 1'b0;
    logic [7:0]  spi_i_tdata;
    logic        spi_o_tvalid = 1'b0, spi_o_tready;
    logic [7:0]  spi_o_tdata = '0;
    logic        m_tvalid, m_tready = 1'b0, m_tlast;
    logic [7:0]  m_tdata;
    logic        csn;

    always #5 clk = ~clk;

    axis_spi_flash_reader #(
        .CMD_BYTE(8'h03), .ADDR_BYTES(AB), .LEN_WIDTH(16),
        .CS_SETUP_CYCLES(SU), .CS_HOLD_CYCLES(HO), .CS_IDLE_CYCLES(ID)
    ) dut (
        .clk(clk), .sresetn(sresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .spi_i_tvalid(spi_i_tvalid), .spi_i_tready(spi_i_tready), .spi_i_tdata(spi_i_tdata),
        .spi_o_tvalid(spi_o_tvalid), .spi_o_tready(spi_o_tready), .spi_o_tdata(spi_o_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .csn(csn)
    );

    int tests = 0, fails = 0;
    logic [23:0] rq_addr[$];
    logic [15:0] rq_len[$];
    logic [7:0]  exp_mosi[$], mosi_log[$];
    logic [8:0]  exp_beat[$], m_log[$];
    int k = 0, lat = 0, lo_cnt = 0, hi_cnt = 0, hold_cnt = 0, duty = 100, beats = 0;
    bit busy = 0, o_done = 0, hold_track = 0, gap_arm = 0;
    logic [23:0] f_addr = '0;
    logic [7:0]  resp = '0;
    logic [7:0]  t2_mosi[8] = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [8:0]  t2_beat[4] = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h1A3};
    logic [8:0]  b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // Flash contents; 0x123456.. reads A0 A1 A2 A3
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] + (a[15:8] ^ a[23:16]) + 8'h24;
    endfunction

    task automatic cycle();
        @(negedge clk);
        if (o_done) begin
            spi_o_tvalid = 1'b0;
            o_done = 0;
        end
        if (busy && !spi_o_tvalid && lat > 0) begin
            lat--;
            if (lat == 0) begin
                spi_o_tvalid = 1'b1;
                spi_o_tdata = resp;
            end
        end
        spi_i_tready = !busy && spi_i_tvalid === 1'b1 && ($urandom_range(99) < 70);
        m_tready = $urandom_range(99) < duty;
        req_valid = rq_addr.size() > 0;
        if (req_valid) begin
            req_addr = rq_addr[0];
            req_len = rq_len[0];
        end
        #1;
        if (hold_track) begin
            if (csn === 1'b0) hold_cnt++;
            else begin
                chk("cs_hold", hold_cnt, HO);
                hold_track = 0;
            end
        end
        if (csn === 1'b1) k = 0;
        if (req_valid && req_ready === 1'b1) begin
            if (gap_arm) chk("cs_idle_gap", hi_cnt >= ID, 1);
            gap_arm = 0;
            beats = 0;
            exp_mosi.push_back(8'h03);
            for (int i = AB - 1; i >= 0; i--) exp_mosi.push_back(req_addr[8*i +: 8]);
            for (int i = 0; i <= int'(req_len); i++) begin
                exp_mosi.push_back(8'h00);
                exp_beat.push_back({i == int'(req_len), flash_byte(req_addr + 24'(i))});
            end
            void'(rq_addr.pop_front());
            void'(rq_len.pop_front());
        end
        if (spi_i_tvalid === 1'b1 && spi_i_tready) begin
            chk("csn_low_mosi", csn, 0);
            if (k == 0) chk("cs_setup", lo_cnt >= SU, 1);
            if (exp_mosi.size() == 0) fail("mosi_extra");
            else chk("mosi", spi_i_tdata, exp_mosi.pop_front());
            mosi_log.push_back(spi_i_tdata);
            if (k >= 1 && k <= AB) f_addr = {f_addr[15:0], spi_i_tdata};
            resp = (k <= AB) ? 8'hE0 + 8'(k) : flash_byte(f_addr + 24'(k - AB - 1));
            k++;
            busy = 1;
            lat = $urandom_range(3, 1);
        end
        if (spi_o_tvalid && spi_o_tready === 1'b1) begin
            o_done = 1;
            busy = 0;
        end
        if (m_tvalid === 1'b1 && !m_tready) chk("bp_stall", spi_o_tready, 0);
        if (m_tvalid === 1'b1 && m_tready) begin
            if (exp_beat.size() == 0) fail("beat_extra");
            else chk("beat", {m_tlast, m_tdata}, exp_beat.pop_front());
            m_log.push_back({m_tlast, m_tdata});
            beats++;
            if (m_tlast) begin
                hold_track = 1;
                hold_cnt = 0;
                gap_arm = 1;
            end
        end
        if (csn === 1'b1) begin
            hi_cnt++;
            lo_cnt = 0;
        end else begin
            lo_cnt++;
            hi_cnt = 0;
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((rq_addr.size() > 0 || exp_beat.size() > 0 || hold_track) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) fail("timeout");
        chk("mosi_left", exp_mosi.size(), 0);
    endtask

    task automatic req(input logic [23:0] a, input logic [15:0] l);
        rq_addr.push_back(a);
        rq_len.push_back(l);
    endtask

    task automatic clear_logs();
        mosi_log.delete();
        m_log.delete();
    endtask

    initial begin
        // T1 reset
        repeat (5) cycle();
        chk("rst_csn", csn, 1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_spi_i_tvalid", spi_i_tvalid, 0);
        chk("rst_spi_o_tready", spi_o_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        sresetn = 1'b1;
        // T2 literal read
        clear_logs();
        req(24'h123456, 16'd3);
        run(2000);
        chk("t2_mosi_count", mosi_log.size(), 8);
        for (int i = 0; i < 8 && i < mosi_log.size(); i++) chk("t2_mosi", mosi_log[i], t2_mosi[i]);
        chk("t2_beat_count", m_log.size(), 4);
        for (int i = 0; i < 4 && i < m_log.size(); i++) chk("t2_beat", m_log[i], t2_beat[i]);
        // T3 single byte
        clear_logs();
        req(24'($urandom), 16'd0);
        run(2000);
        chk("t3_beat_count", m_log.size(), 1);
        b = m_log.size() > 0 ? m_log[0] : 9'h0;
        chk("t3_tlast", b[8], 1);
        // T4 downstream backpressure
        clear_logs();
        duty = 30;
        req(24'($urandom), 16'd15);
        run(6000);
        chk("t4_beat_count", m_log.size(), 16);
        // T5 back-to-back
        clear_logs();
        duty = 100;
        req(24'hABCDEF, 16'd2);
        req(24'h000100, 16'd4);
        run(4000);
        chk("t5_beat_count", m_log.size(), 8);
        chk("t5_second_cmd", mosi_log.size() > 7 ? mosi_log[7] : 8'hXX, 8'h03);
        // T6 abort during data phase
        clear_logs();
        duty = 60;
        req(24'h0F0F00, 16'd7);
        begin
            int n = 0;
            while (!(beats >= 3 && spi_i_tvalid === 1'b1) && n < 3000) begin
                cycle();
                n++;
            end
            if (n >= 3000) fail("t6_reach_data");
        end
        sresetn = 1'b0;
        busy = 0;
        o_done = 0;
        spi_o_tvalid = 1'b0;
        hold_track = 0;
        gap_arm = 0;
        exp_mosi.delete();
        exp_beat.delete();
        cycle();
        chk("t6_csn", csn, 1);
        chk("t6_m_tvalid", m_tvalid, 0);
        chk("t6_spi_i_tvalid", spi_i_tvalid, 0);
        b = m_log.size() > 0 ? m_log[m_log.size()-1] : 9'h0;
        chk("t6_no_tlast", b[8], 0);
        sresetn = 1'b1;
        clear_logs();
        req(24'h0F0F00, 16'd7);
        run(4000);
        chk("t6_after_count", m_log.size(), 8);
        // Randomized requests
        for (int it = 0; it < 8; it++) begin
            clear_logs();
            duty = $urandom_range(100, 20);
            req(24'($urandom), 16'($urandom_range(12)));
            if ($urandom_range(1)) req(24'($urandom), 16'($urandom_range(12)));
            run(8000);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
